// File: rtl/ascon_pack.sv
// Shared ASCON types and constants: the 5x64-bit state, round bookkeeping
// and the state encoding of the iterative permutation controller.
package ascon_pack;

  // Word i of the state lives in element [i]; word 0 is the rate word.
  typedef logic [4:0][63:0] type_state;

  localparam int ROUNDS_A_DEFAULT = 12;
  localparam int ROUNDS_B_DEFAULT = 6;

  // The round constant index always runs up to 11; p^b simply starts later.
  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [3:0] FIRST_A_DEFAULT = 4'd0;
  localparam logic [3:0] FIRST_B_DEFAULT = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } type_fsm;

  // Round constant for index i: high nibble counts down from F, low nibble up from 0.
  function automatic logic [7:0] round_constant(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

  // 64-bit rotate right by a fixed amount.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/permutation_elementaire.sv
// One combinational ASCON round: constant addition, bitsliced S-box layer,
// then the per-word linear diffusion layer.
module permutation_elementaire
  import ascon_pack::*;
(
  input  logic [3:0] round_i,
  input  type_state  state_i,
  output type_state  state_o
);

  type_state   after_c;
  type_state   after_s;
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // Constant addition touches only the low byte of word 2.
  always_comb begin
    after_c = state_i;
    after_c[2][7:0] = state_i[2][7:0] ^ round_constant(round_i);
  end

  // Bitsliced 5-bit S-box applied to all 64 columns at once.
  always_comb begin
    x0 = after_c[0] ^ after_c[4];
    x4 = after_c[4] ^ after_c[3];
    x2 = after_c[2] ^ after_c[1];
    x1 = after_c[1];
    x3 = after_c[3];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    after_s[0] = x0;
    after_s[1] = x1;
    after_s[2] = x2;
    after_s[3] = x3;
    after_s[4] = x4;
  end

  // Linear layer: each word XORed with two rotations of itself.
  always_comb begin
    state_o[0] = after_s[0] ^ rotr(after_s[0], 19) ^ rotr(after_s[0], 28);
    state_o[1] = after_s[1] ^ rotr(after_s[1], 61) ^ rotr(after_s[1], 39);
    state_o[2] = after_s[2] ^ rotr(after_s[2], 1)  ^ rotr(after_s[2], 6);
    state_o[3] = after_s[3] ^ rotr(after_s[3], 10) ^ rotr(after_s[3], 17);
    state_o[4] = after_s[4] ^ rotr(after_s[4], 7)  ^ rotr(after_s[4], 41);
  end

endmodule

// File: rtl/permutation_iter.sv
// Iterative ASCON permutation: one round per clock through a single round
// instance, running p^a or p^b with optional data/key injection on entry
// and key injection on exit.
module permutation_iter
  import ascon_pack::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEFAULT,
  parameter int ROUNDS_B = ROUNDS_B_DEFAULT
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  type_state    state_i,
  input  logic [63:0]  data_i,
  input  logic         xor_data_i,
  input  logic [127:0] key_i,
  input  logic         xor_key_begin_i,
  input  logic         xor_key_end_i,
  output type_state    state_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] FIRST_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] FIRST_B = 4'(12 - ROUNDS_B);

  type_fsm    fsm_q;
  type_state  state_q;
  type_state  injected;
  type_state  round_in;
  type_state  round_out;
  type_state  next_state;
  logic [3:0] counter_q;
  logic [3:0] first_idx;
  logic [3:0] round_idx;
  logic       key_end_q;
  logic       key_end_now;
  logic       load;
  logic       last;

  // A start is honoured whenever no run is in flight, including the DONE cycle.
  assign load        = start_i && (fsm_q != ST_RUN);
  assign first_idx   = mode_i ? FIRST_B : FIRST_A;
  assign round_in    = load ? injected : state_q;
  assign round_idx   = load ? first_idx : counter_q;
  assign last        = (round_idx == LAST_ROUND);
  assign key_end_now = load ? xor_key_end_i : key_end_q;

  // Entry injections: data block into word 0, key into words 1-2.
  always_comb begin
    injected = state_i;
    if (xor_data_i) begin
      injected[0] = state_i[0] ^ data_i;
    end
    if (xor_key_begin_i) begin
      injected[1] = state_i[1] ^ key_i[127:64];
      injected[2] = state_i[2] ^ key_i[63:0];
    end
  end

  permutation_elementaire u_round (
    .round_i (round_idx),
    .state_i (round_in),
    .state_o (round_out)
  );

  // Exit injection of the key into words 3-4, only on the final round.
  always_comb begin
    next_state = round_out;
    if (last && key_end_now) begin
      next_state[3] = round_out[3] ^ key_i[127:64];
      next_state[4] = round_out[4] ^ key_i[63:0];
    end
  end

  // Controller and state register; the first round is applied on the load edge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q     <= ST_IDLE;
      state_q   <= '0;
      counter_q <= 4'd0;
      key_end_q <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      case (fsm_q)
        ST_RUN: begin
          state_q <= next_state;
          if (last) begin
            fsm_q     <= ST_DONE;
            counter_q <= 4'd0;
            busy_o    <= 1'b0;
          end else begin
            counter_q <= counter_q + 4'd1;
          end
        end
        default: begin
          if (load) begin
            state_q   <= next_state;
            key_end_q <= xor_key_end_i;
            if (last) begin
              fsm_q     <= ST_DONE;
              counter_q <= 4'd0;
              busy_o    <= 1'b0;
            end else begin
              fsm_q     <= ST_RUN;
              counter_q <= first_idx + 4'd1;
              busy_o    <= 1'b1;
            end
          end else begin
            fsm_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign done_o  = (fsm_q == ST_DONE);
  assign round_o = ((fsm_q == ST_RUN) || load) ? round_idx : 4'd0;

endmodule
